// File: rtl/bias_loader.sv
`default_nettype none
// ============================================================================
// Module   : bias_loader
// Brief    : Reloadable per-channel bias bank. Assembles byte-serial beats into
//            WIDTH-bit words in a shadow bank and commits all channels at once.
// Revision : 1.0 - initial release
// ============================================================================
module bias_loader #(
    parameter int K_CHANNELS = 4,
    parameter int WIDTH      = 32,
    parameter int IN_WIDTH   = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    input  logic [IN_WIDTH-1:0]           s_data_i,
    input  logic                          s_valid_i,
    output logic                          s_ready_o,
    output logic [K_CHANNELS*WIDTH-1:0]   bias_o,
    output logic                          loading_o,
    output logic                          done_o,
    output logic                          loaded_o
);

    localparam int BEATS  = WIDTH / IN_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WORD_W = (K_CHANNELS > 1) ? $clog2(K_CHANNELS) : 1;

    localparam logic [BEAT_W-1:0] C_LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [WORD_W-1:0] C_LAST_WORD = WORD_W'(K_CHANNELS - 1);

    if ((WIDTH % IN_WIDTH) != 0) begin : g_width_check
        $error("bias_loader: WIDTH must be a multiple of IN_WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t                               r_state;
    logic [K_CHANNELS-1:0][WIDTH-1:0]     r_shadow;
    logic [BEAT_W-1:0]                    r_beat_cnt;
    logic [WORD_W-1:0]                    r_word_cnt;

    logic w_accept;
    logic w_last_beat;
    logic w_last_word;

    assign w_accept    = s_valid_i & s_ready_o;
    assign w_last_beat = (r_beat_cnt == C_LAST_BEAT);
    assign w_last_word = (r_word_cnt == C_LAST_WORD);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_shadow   <= '0;
            r_beat_cnt <= '0;
            r_word_cnt <= '0;
            s_ready_o  <= 1'b0;
            bias_o     <= '0;
            loading_o  <= 1'b0;
            done_o     <= 1'b0;
            loaded_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_state    <= S_LOAD;
                        r_beat_cnt <= '0;
                        r_word_cnt <= '0;
                        s_ready_o  <= 1'b1;
                        loading_o  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_shadow[r_word_cnt][r_beat_cnt*IN_WIDTH +: IN_WIDTH] <= s_data_i;
                        if (w_last_beat) begin
                            r_beat_cnt <= '0;
                            if (w_last_word) begin
                                r_state   <= S_COMMIT;
                                s_ready_o <= 1'b0;
                                loading_o <= 1'b0;
                            end else begin
                                r_word_cnt <= r_word_cnt + 1'b1;
                            end
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
                S_COMMIT: begin
                    // Whole bank moves in one edge so consumers never see a mix of layers.
                    bias_o   <= r_shadow;
                    done_o   <= 1'b1;
                    loaded_o <= 1'b1;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state   <= S_IDLE;
                    s_ready_o <= 1'b0;
                    loading_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bias_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_bias_loader
// Brief    : Scoreboard bench for bias_loader (K=4/32/8 and K=1/24/24 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bias_loader;

    localparam int K  = 4;
    localparam int W  = 32;
    localparam int NB = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [7:0]   s_data;
    logic         s_valid;
    logic         s_ready;
    logic [127:0] bias;
    logic         loading;
    logic         done;
    logic         loaded;

    logic         start2;
    logic [23:0]  s_data2;
    logic         s_valid2;
    logic         s_ready2;
    logic [23:0]  bias2;
    logic         loading2;
    logic         done2;
    logic         loaded2;

    always #5 clk = ~clk;

    bias_loader #(.K_CHANNELS(K), .WIDTH(W), .IN_WIDTH(8)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .s_data_i(s_data),
        .s_valid_i(s_valid), .s_ready_o(s_ready), .bias_o(bias),
        .loading_o(loading), .done_o(done), .loaded_o(loaded)
    );

    bias_loader #(.K_CHANNELS(1), .WIDTH(24), .IN_WIDTH(24)) dut_k1 (
        .clk_i(clk), .rst_i(rst), .start_i(start2), .s_data_i(s_data2),
        .s_valid_i(s_valid2), .s_ready_o(s_ready2), .bias_o(bias2),
        .loading_o(loading2), .done_o(done2), .loaded_o(loaded2)
    );

    typedef struct {
        logic [127:0] bias;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int           vectors = 0;
    int           miscompares = 0;
    int           cyc = 0;
    logic [127:0] model_bias = '0;
    bit           model_loaded = 1'b0;
    bit           mon_en = 1'b0;
    logic [7:0]   stim_bytes [NB];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: word k is bytes 4k..4k+3, least-significant byte first.
    function automatic logic [127:0] model_vector();
        logic [127:0] v = '0;
        for (int k = 0; k < K; k++) begin
            logic [127:0] word = '0;
            for (int b = 3; b >= 0; b--)
                word = word * 256 + 128'(stim_bytes[k*4 + b]);
            v = v | (word << (32 * k));
        end
        return v;
    endfunction

    task automatic set_words(input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3);
        logic [31:0] ws [4];
        ws[0] = w0; ws[1] = w1; ws[2] = w2; ws[3] = w3;
        for (int k = 0; k < 4; k++)
            for (int b = 0; b < 4; b++)
                stim_bytes[k*4 + b] = 8'((ws[k] >> (8 * b)) % 256);
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 128'(done), 128'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("commit_bias", bias, mon_e.bias);
                    check("done_cycle", 128'(cyc), 128'(mon_e.cyc));
                    model_bias   = mon_e.bias;
                    model_loaded = 1'b1;
                end
            end else begin
                check("bias_hold", bias, model_bias);
            end
            check("loaded", 128'(loaded), 128'(model_loaded));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        check("rst_bias", bias, 128'd0);
        check("rst_loaded", 128'(loaded), 128'd0);
        check("rst_ready", 128'(s_ready), 128'd0);
        check("rst_loading", 128'(loading), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_bias_k1", 128'(bias2), 128'd0);
        model_bias   = '0;
        model_loaded = 1'b0;
        sb.delete();
        rst = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] d, output int c);
        int n   = 0;
        bit acc = 1'b0;
        c = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = s_ready;
            c   = cyc;
            tick();
            n++;
        end
        s_valid = 1'b0;
        if (!acc) check("beat_accept_timeout", 128'(acc), 128'd1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 10) begin
            tick();
            n++;
        end
        check("drain", 128'(sb.size()), 128'd0);
    endtask

    task automatic do_load(input int gap_max, input bit mid_start);
        int c = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ready_after_start", 128'(s_ready), 128'd1);
        check("loading_in_load", 128'(loading), 128'd1);
        for (int i = 0; i < NB; i++) begin
            repeat ($urandom_range(0, gap_max)) tick();
            if (mid_start && i == 5) start = 1'b1;
            send_beat(stim_bytes[i], c);
            start = 1'b0;
        end
        sb.push_back('{model_vector(), c + 2});
        @(negedge clk);
        check("ready_drops", 128'(s_ready), 128'd0);
        tick();
        wait_drain();
    endtask

    initial begin
        int c = 0;
        int dcyc = -1;
        rst = 1'b1; start = 1'b0; s_data = '0; s_valid = 1'b0;
        start2 = 1'b0; s_data2 = '0; s_valid2 = 1'b0;
        tick();
        do_reset();
        mon_en = 1'b1;

        // Test 1: sequential bytes, no gaps
        for (int i = 0; i < NB; i++) stim_bytes[i] = 8'(i);
        do_load(0, 1'b0);
        check("t1_word0", 128'(bias[31:0]),   128'h03020100);
        check("t1_word3", 128'(bias[127:96]), 128'h0F0E0D0C);
        check("t1_ready_after", 128'(s_ready), 128'd0);

        // Test 2: preload, then gapped reload; monitor checks every cycle
        set_words(32'h11111111, 32'h11111111, 32'h11111111, 32'h11111111);
        do_load(0, 1'b0);
        for (int i = 0; i < NB; i++) stim_bytes[i] = 8'($urandom);
        do_load(3, 1'b0);

        // Test 3: idle traffic is not consumed; start mid-load ignored
        s_valid = 1'b1;
        s_data  = 8'hAA;
        repeat (5) begin
            @(negedge clk);
            check("idle_ready", 128'(s_ready), 128'd0);
            tick();
        end
        s_valid = 1'b0;
        for (int i = 0; i < NB; i++) stim_bytes[i] = 8'($urandom);
        do_load(1, 1'b1);

        // Test 4: reset after 7 beats
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) send_beat(8'($urandom), c);
        do_reset();
        check("t4_loading", 128'(loading), 128'd0);
        for (int i = 0; i < NB; i++) stim_bytes[i] = 8'($urandom);
        do_load(2, 1'b0);

        // Test 5: sign/edge patterns
        set_words(32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h00000000);
        do_load(0, 1'b0);
        check("t5_words", bias, 128'h00000000_7FFFFFFF_80000000_FFFFFFFF);

        // Random loads
        repeat (5) begin
            for (int i = 0; i < NB; i++) stim_bytes[i] = 8'($urandom);
            do_load(2, 1'b0);
        end

        // Test 6: single-channel, single-beat words
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        check("k1_ready", 128'(s_ready2), 128'd1);
        s_valid2 = 1'b1;
        s_data2  = 24'hABCDEF;
        @(negedge clk);
        c = cyc;
        check("k1_accept", 128'(s_ready2), 128'd1);
        tick();
        s_valid2 = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (done2 && dcyc < 0) begin
                dcyc = cyc;
                check("k1_bias", 128'(bias2), 128'hABCDEF);
            end
            tick();
        end
        check("k1_done_cycle", 128'(dcyc), 128'(c + 2));
        check("k1_loaded", 128'(loaded2), 128'd1);
        check("k1_ready_after", 128'(s_ready2), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
